axi_wr_arbiter: RTL and testbench

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

---
 rtl/axi_wr_arbiter_pkg.sv | 23 ++
 rtl/axi_wr_arbiter_if.sv | 48 ++++
 rtl/axi_wr_arbiter_pick.sv | 13 +
 rtl/axi_wr_arbiter.sv | 112 +++++++++++
 tb/tb_axi_wr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_wr_arbiter_pkg.sv
// Shared definitions for the two-requester AXI write arbiter: state encoding,
// requester count and the default bus widths derived from the DRAM geometry.
package axi_arb_pkg;

    localparam int NUM_REQ  = 2;

    localparam int ROW_BITS = 14;
    localparam int COL_BITS = 10;
    localparam int BA_BITS  = 3;
    localparam int DQ_BITS  = 16;

    localparam int DEF_ADDR_WIDTH = ROW_BITS + COL_BITS + BA_BITS;
    localparam int DEF_DATA_WIDTH = DQ_BITS * 2;
    localparam int DEF_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// Bundle of requester-side (s_*) and controller-side (m_*) write channels.
// The arbiter uses the slave view; the surrounding requesters/controller use master.
interface axi_wr_arbiter_if #(
    parameter int ADDR_WIDTH = axi_arb_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = axi_arb_pkg::DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = axi_arb_pkg::DEF_LEN_WIDTH
);
    import axi_arb_pkg::*;

    logic [NUM_REQ-1:0]            s_awvalid;
    logic [NUM_REQ-1:0]            s_awready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] s_awaddr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  s_awlen;
    logic [NUM_REQ-1:0]            s_wvalid;
    logic [NUM_REQ-1:0]            s_wready;
    logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata;
    logic [NUM_REQ-1:0]            s_bvalid;
    logic [NUM_REQ-1:0]            s_bready;

    logic                          m_awvalid;
    logic                          m_awready;
    logic [ADDR_WIDTH-1:0]         m_awaddr;
    logic [LEN_WIDTH-1:0]          m_awlen;
    logic                          m_wvalid;
    logic                          m_wready;
    logic [DATA_WIDTH-1:0]         m_wdata;
    logic                          m_wlast;
    logic                          m_bvalid;
    logic                          m_bready;
    logic                          grant;

    modport slave (
        input  s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_bready,
        input  m_awready, m_wready, m_bvalid,
        output s_awready, s_wready, s_bvalid,
        output m_awvalid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready,
        output grant
    );

    modport master (
        output s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_bready,
        output m_awready, m_wready, m_bvalid,
        input  s_awready, s_wready, s_bvalid,
        input  m_awvalid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready,
        input  grant
    );

endinterface

// File: rtl/axi_wr_arbiter_pick.sv
// Two-way round-robin winner select: the priority holder wins if it requests,
// otherwise the other requester does. Only meaningful when some request is set.
module rr_pick2
    import axi_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               prio,
    output logic               win
);

    assign win = req[prio] ? prio : ~prio;

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI write arbiter: one burst at a time, round-robin between
// requesters, with the winner decided only while idle.
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
)(
    input  logic             clk,
    input  logic             rst,
    axi_wr_arbiter_if.slave  bus
);

    arb_state_t            state;
    logic                  prio;
    logic                  grant_q;
    logic                  win;
    logic [LEN_WIDTH:0]    cnt;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [LEN_WIDTH-1:0]  awlen_q;
    logic                  w_hs;
    logic                  last_beat;

    rr_pick2 u_pick (
        .req  (bus.s_awvalid),
        .prio (prio),
        .win  (win)
    );

    // The extra counter bit lets a 256-beat burst finish without wrapping.
    assign last_beat = (cnt == {1'b0, awlen_q});
    assign w_hs      = bus.m_wvalid & bus.m_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            prio     <= 1'b0;
            grant_q  <= 1'b0;
            cnt      <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.s_awvalid) begin
                        grant_q  <= win;
                        awaddr_q <= win ? bus.s_awaddr[NUM_REQ*ADDR_WIDTH-1:ADDR_WIDTH]
                                        : bus.s_awaddr[ADDR_WIDTH-1:0];
                        awlen_q  <= win ? bus.s_awlen[NUM_REQ*LEN_WIDTH-1:LEN_WIDTH]
                                        : bus.s_awlen[LEN_WIDTH-1:0];
                        state    <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (bus.m_awready) begin
                        cnt   <= '0;
                        state <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        cnt <= cnt + (LEN_WIDTH+1)'(1);
                        if (last_beat) begin
                            state <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (bus.m_bvalid && bus.s_bready[grant_q]) begin
                        prio  <= ~grant_q;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshakes pass straight through to the granted requester only.
    always_comb begin
        bus.s_awready = '0;
        bus.s_wready  = '0;
        bus.s_bvalid  = '0;
        bus.m_awvalid = (state == ST_AW);
        bus.m_wvalid  = 1'b0;
        bus.m_wlast   = 1'b0;
        bus.m_bready  = 1'b0;
        case (state)
            ST_AW: begin
                bus.s_awready[grant_q] = bus.m_awready;
            end
            ST_W: begin
                bus.m_wvalid          = bus.s_wvalid[grant_q];
                bus.s_wready[grant_q] = bus.m_wready;
                bus.m_wlast           = last_beat;
            end
            ST_B: begin
                bus.s_bvalid[grant_q] = bus.m_bvalid;
                bus.m_bready          = bus.s_bready[grant_q];
            end
            default: ;
        endcase
    end

    assign bus.m_wdata  = grant_q ? bus.s_wdata[NUM_REQ*DATA_WIDTH-1:DATA_WIDTH]
                                  : bus.s_wdata[DATA_WIDTH-1:0];
    assign bus.m_awaddr = awaddr_q;
    assign bus.m_awlen  = awlen_q;
    assign bus.grant    = grant_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: requester/controller models drive the bus,
// a negedge monitor pops expected AW/W/B transactions from scoreboard queues.
module tb_axi_wr_arbiter;
    import axi_arb_pkg::*;

    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int LW = DEF_LEN_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    axi_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; logic [DW-1:0] base; } burst_t;
    typedef struct { logic grant; logic [AW-1:0] addr; logic [LW-1:0] len; bit b2b; } aw_exp_t;
    typedef struct { logic grant; logic [DW-1:0] data; logic last; } w_exp_t;
    typedef enum logic [1:0] { PH_IDLE, PH_AW, PH_W, PH_B } ph_t;

    burst_t  rq0[$];
    burst_t  rq1[$];
    aw_exp_t exp_aw[$];
    w_exp_t  exp_w[$];
    logic    exp_b[$];

    ph_t    ph   [2];
    int     beat [2];
    burst_t cur  [2];
    bit     junk1;
    bit     toggle_wready;
    bit     bpend;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_b_cyc = 0;

    logic [1:0] f_aw, f_w, f_b;
    logic       f_mw_last, f_mb;
    aw_exp_t    mon_a;
    w_exp_t     mon_w;
    logic       mon_g;
    logic       ng;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    // Queue one burst on requester n and record the transactions it must produce.
    task automatic applyStimulus(input int n, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                                 input logic [DW-1:0] base, input bit b2b);
        burst_t  b;
        aw_exp_t a;
        w_exp_t  w;
        b.addr = addr; b.len = len; b.base = base;
        if (n == 0) rq0.push_back(b); else rq1.push_back(b);
        a.grant = (n == 1); a.addr = addr; a.len = len; a.b2b = b2b;
        exp_aw.push_back(a);
        for (int k = 0; k <= int'(len); k++) begin
            w.grant = (n == 1);
            w.data  = base + DW'(k);
            w.last  = (k == int'(len));
            exp_w.push_back(w);
        end
        exp_b.push_back(n == 1);
    endtask

    task automatic drive_inputs();
        logic [1:0] awv;
        logic [1:0] wv;
        awv = '0;
        wv  = '0;
        for (int n = 0; n < 2; n++) begin
            awv[n] = (ph[n] == PH_AW);
            wv[n]  = (ph[n] == PH_W);
        end
        bus.s_awvalid = awv;
        bus.s_awaddr  = {cur[1].addr, cur[0].addr};
        bus.s_awlen   = {cur[1].len, cur[0].len};
        bus.s_wdata   = {cur[1].base + DW'(beat[1]), cur[0].base + DW'(beat[0])};
        if (junk1 && ph[1] != PH_W) begin
            wv[1] = 1'b1;
            bus.s_wdata[2*DW-1:DW] = DW'(32'hBAD0_0000);
        end
        bus.s_wvalid  = wv;
        bus.s_bready  = 2'b11;
        bus.m_awready = 1'b1;
        bus.m_bvalid  = bpend;
    endtask

    task automatic update_model();
        if (f_mw_last) bpend = 1'b1;
        if (f_mb)      bpend = 1'b0;
        for (int n = 0; n < 2; n++) begin
            case (ph[n])
                PH_AW: if (f_aw[n]) begin ph[n] = PH_W; beat[n] = 0; end
                PH_W: if (f_w[n]) begin
                    beat[n]++;
                    if (beat[n] > int'(cur[n].len)) ph[n] = PH_B;
                end
                PH_B: if (f_b[n]) begin
                    if (n == 0) rq0.delete(0); else rq1.delete(0);
                    ph[n] = PH_IDLE;
                end
                default: ;
            endcase
            if (ph[n] == PH_IDLE) begin
                if (n == 0 && rq0.size() > 0) begin cur[0] = rq0[0]; ph[0] = PH_AW; beat[0] = 0; end
                if (n == 1 && rq1.size() > 0) begin cur[1] = rq1[0]; ph[1] = PH_AW; beat[1] = 0; end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        update_model();
        bus.m_wready = toggle_wready ? ~bus.m_wready : 1'b1;
        drive_inputs();
    endtask

    task automatic flush();
        rq0.delete(); rq1.delete();
        exp_aw.delete(); exp_w.delete(); exp_b.delete();
        for (int n = 0; n < 2; n++) begin
            ph[n] = PH_IDLE;
            beat[n] = 0;
            cur[n].addr = '0; cur[n].len = '0; cur[n].base = '0;
        end
        bpend = 1'b0;
        junk1 = 1'b0;
        toggle_wready = 1'b0;
        bus.m_wready = 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        flush();
        drive_inputs();
        tick();
        rst = 1'b0;
    endtask

    function automatic bit model_idle();
        return rq0.size() == 0 && rq1.size() == 0 && exp_aw.size() == 0 && exp_w.size() == 0 &&
               exp_b.size() == 0 && ph[0] == PH_IDLE && ph[1] == PH_IDLE && !bpend;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!model_idle() && n < budget) begin
            tick();
            n++;
        end
        if (!model_idle()) reportFail({name, "_timeout"});
    endtask

    // Monitor: handshakes are stable at the falling edge, so compare there.
    always @(negedge clk) begin
        if (rst) begin
            f_aw = '0; f_w = '0; f_b = '0; f_mw_last = 1'b0; f_mb = 1'b0;
        end else begin
            cyc++;
            f_aw      = bus.s_awvalid & bus.s_awready;
            f_w       = bus.s_wvalid & bus.s_wready;
            f_b       = bus.s_bvalid & bus.s_bready;
            f_mw_last = bus.m_wvalid & bus.m_wready & bus.m_wlast;
            f_mb      = bus.m_bvalid & bus.m_bready;
            ng = ~bus.grant;
            checkOutput("ungranted_quiet",
                        64'({bus.s_awready[ng], bus.s_wready[ng], bus.s_bvalid[ng],
                             bus.m_awvalid ? 1'b0 : |bus.s_awready}), 64'(0));
            if (bus.m_awvalid && bus.m_awready) begin
                if (exp_aw.size() == 0) reportFail("aw_unexpected");
                else begin
                    mon_a = exp_aw.pop_front();
                    checkOutput("aw_grant", 64'(bus.grant), 64'(mon_a.grant));
                    checkOutput("aw_addr", 64'(bus.m_awaddr), 64'(mon_a.addr));
                    checkOutput("aw_len", 64'(bus.m_awlen), 64'(mon_a.len));
                    if (mon_a.b2b) checkOutput("aw_b2b_gap", 64'(cyc - last_b_cyc), 64'(2));
                end
            end
            if (bus.m_wvalid && bus.m_wready) begin
                if (exp_w.size() == 0) reportFail("w_unexpected");
                else begin
                    mon_w = exp_w.pop_front();
                    checkOutput("w_grant", 64'(bus.grant), 64'(mon_w.grant));
                    checkOutput("w_data", 64'(bus.m_wdata), 64'(mon_w.data));
                    checkOutput("w_last", 64'(bus.m_wlast), 64'(mon_w.last));
                end
            end
            if (bus.m_bvalid && bus.m_bready) begin
                if (exp_b.size() == 0) reportFail("b_unexpected");
                else begin
                    mon_g = exp_b.pop_front();
                    checkOutput("b_grant", 64'(bus.grant), 64'(mon_g));
                    checkOutput("b_svalid", 64'(bus.s_bvalid), 64'(mon_g ? 2'b10 : 2'b01));
                end
                last_b_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] start");
        apply_reset();
        @(negedge clk);
        checkOutput("reset_handshakes",
                    64'({bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bready,
                         bus.s_awready, bus.s_wready, bus.s_bvalid}), 64'(0));
        checkOutput("reset_awaddr", 64'(bus.m_awaddr), 64'(0));
        checkOutput("reset_awlen", 64'(bus.m_awlen), 64'(0));
        checkOutput("reset_grant", 64'(bus.grant), 64'(0));

        // Single requester, 4 beats, one-cycle grant latency.
        applyStimulus(0, AW'('h40), 8'd3, DW'('h1000_0000), 1'b0);
        tick();
        @(negedge clk);
        checkOutput("aw_latency_before", 64'(bus.m_awvalid), 64'(0));
        tick();
        @(negedge clk);
        checkOutput("aw_latency_after", 64'(bus.m_awvalid), 64'(1));
        wait_done("single", 100);

        // Simultaneous requests after reset: s0 first, s1 straight after.
        apply_reset();
        applyStimulus(0, AW'('h100), 8'd1, DW'('h2000_0000), 1'b0);
        applyStimulus(1, AW'('h200), 8'd2, DW'('h3000_0000), 1'b1);
        wait_done("pair", 200);

        // Continuous contention alternates 0,1,0,1.
        applyStimulus(0, AW'('h500), 8'd1, DW'('h4000_0000), 1'b0);
        applyStimulus(1, AW'('h510), 8'd0, DW'('h4100_0000), 1'b1);
        applyStimulus(0, AW'('h520), 8'd2, DW'('h4200_0000), 1'b1);
        applyStimulus(1, AW'('h530), 8'd1, DW'('h4300_0000), 1'b1);
        wait_done("alternate", 300);

        // Ungranted s1 pushing data must never be accepted.
        junk1 = 1'b1;
        applyStimulus(0, AW'('h600), 8'd2, DW'('h5000_0000), 1'b0);
        wait_done("junk", 100);
        junk1 = 1'b0;

        // Maximum burst with m_wready toggling.
        toggle_wready = 1'b1;
        applyStimulus(0, AW'('h700), 8'd255, DW'('h6000_0000), 1'b0);
        wait_done("long", 1500);
        toggle_wready = 1'b0;

        // Reset in the middle of s1's data phase.
        applyStimulus(1, AW'('h800), 8'd7, DW'('h7000_0000), 1'b0);
        begin
            int n;
            n = 0;
            while (beat[1] < 2 && n < 50) begin tick(); n++; end
            if (beat[1] < 2) reportFail("midburst_timeout");
        end
        apply_reset();
        @(negedge clk);
        checkOutput("midreset_handshakes",
                    64'({bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bready,
                         bus.s_awready, bus.s_wready, bus.s_bvalid}), 64'(0));
        checkOutput("midreset_awaddr", 64'(bus.m_awaddr), 64'(0));
        checkOutput("midreset_grant", 64'(bus.grant), 64'(0));

        // Priority is back at s0 after the abandoned s1 burst.
        applyStimulus(0, AW'('h300), 8'd0, DW'('h8000_0000), 1'b0);
        applyStimulus(1, AW'('h400), 8'd0, DW'('h9000_0000), 1'b1);
        wait_done("post_reset", 100);

        checkOutput("queues_drained", 64'(exp_aw.size() + exp_w.size() + exp_b.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
